// File: rtl/multadd_pkg.sv
// rtl/multadd_pkg.sv - shared widths, request/result types and the overflow helper for the multadd driver
package multadd_pkg;
  localparam int OPW = 8;
  localparam int RW  = 17;

  typedef struct packed {
    logic [OPW-1:0] a0;
    logic [OPW-1:0] a1;
    logic [OPW-1:0] b0;
    logic [OPW-1:0] b1;
    logic           sel;
  } multadd_req_t;

  typedef struct packed {
    logic [RW-1:0] r;
    logic          ovf;
  } multadd_res_t;

  // True when the exact (34-bit) MAC result does not fit in RW bits.
  function automatic logic calcOvf(input multadd_req_t req);
    logic [33:0] x0, x1, y0, y1, full;
    x0   = 34'(req.a0);
    x1   = 34'(req.a1);
    y0   = 34'(req.b0);
    y1   = 34'(req.b1);
    full = x0 * y0 + x1 * y1;
    if (!req.sel) full = full + x0 * x1 * y0 * y1;
    return |full[33:RW];
  endfunction
endpackage

// File: rtl/multadd_res_fifo.sv
// rtl/multadd_res_fifo.sv - synchronous result FIFO with occupancy count and same-cycle push/pop
module multadd_res_fifo #(
  parameter int W     = 17,
  parameter int DEPTH = 4
) (
  input  logic                     iCLK,
  input  logic                     iRST_N,
  input  logic                     iPUSH,
  input  logic [W-1:0]             iDATA,
  input  logic                     iPOP,
  output logic [W-1:0]             oDATA,
  output logic                     oEMPTY,
  output logic [$clog2(DEPTH):0]   oCOUNT
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wrPtr, rdPtr;
  logic          doPop, doPush;

  assign oEMPTY = (oCOUNT == '0);
  assign doPop  = iPOP && !oEMPTY;
  assign doPush = iPUSH && ((oCOUNT != (AW+1)'(DEPTH)) || doPop);
  // Head reads as zero when empty so nothing stale is ever visible.
  assign oDATA  = oEMPTY ? '0 : mem[rdPtr];

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      wrPtr  <= '0;
      rdPtr  <= '0;
      oCOUNT <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + AW'(1);
      if (doPop)  rdPtr <= rdPtr + AW'(1);
      oCOUNT <= oCOUNT + (AW+1)'(doPush) - (AW+1)'(doPop);
    end
  end

  always_ff @(posedge iCLK) begin
    if (doPush) mem[wrPtr] <= iDATA;
  end
endmodule

// File: rtl/multadd_driver.sv
// rtl/multadd_driver.sv - issue, credit and in-order result return for the registered multiply-add unit
// Optional MULTADD_DRV_OVF_EN adds oRES_OVF, a per-result flag for results that exceed RW bits.
module multadd_driver
  import multadd_pkg::*;
#(
  parameter int MAC_LAT    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic           iCLK,
  input  logic           iRST_N,
  input  logic           iREQ_VALID,
  output logic           oREQ_READY,
  input  logic [OPW-1:0] iREQ_A0,
  input  logic [OPW-1:0] iREQ_A1,
  input  logic [OPW-1:0] iREQ_B0,
  input  logic [OPW-1:0] iREQ_B1,
  input  logic           iREQ_SEL,
  output logic [OPW-1:0] oA0,
  output logic [OPW-1:0] oA1,
  output logic [OPW-1:0] oB0,
  output logic [OPW-1:0] oB1,
  output logic           oSEL,
  input  logic [RW-1:0]  iR,
  output logic           oRES_VALID,
  input  logic           iRES_READY,
  output logic [RW-1:0]  oRES,
  output logic [15:0]    oISSUED
`ifdef MULTADD_DRV_OVF_EN
  ,
  output logic           oRES_OVF
`endif
);
  localparam int PL = MAC_LAT + 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  multadd_req_t  req, opReg;
  logic [PL-1:0] busyPipe;
  logic [CW-1:0] fifoCount;
  logic          fifoEmpty, accept, pop;
  int            credit;

  assign req = '{a0: iREQ_A0, a1: iREQ_A1, b0: iREQ_B0, b1: iREQ_B1, sel: iREQ_SEL};

  // Every op still in the pipe already owns a FIFO slot, so a push can never find it full.
  always_comb begin
    credit = int'(fifoCount);
    for (int i = 0; i < PL; i++) credit = credit + int'(busyPipe[i]);
  end

  assign oREQ_READY = (credit < FIFO_DEPTH);
  assign accept     = iREQ_VALID && oREQ_READY;
  assign oRES_VALID = !fifoEmpty;
  assign pop        = oRES_VALID && iRES_READY;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      opReg    <= '0;
      busyPipe <= '0;
      oISSUED  <= '0;
    end else begin
      busyPipe <= {busyPipe[PL-2:0], accept};
      if (accept) begin
        opReg   <= req;
        oISSUED <= oISSUED + 16'd1;
      end
    end
  end

  assign oA0  = opReg.a0;
  assign oA1  = opReg.a1;
  assign oB0  = opReg.b0;
  assign oB1  = opReg.b1;
  assign oSEL = opReg.sel;

`ifdef MULTADD_DRV_OVF_EN
  localparam int FW = RW + 1;
  logic [PL-1:0] ovfPipe;
  multadd_res_t  fifoIn, fifoOut;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) ovfPipe <= '0;
    else         ovfPipe <= {ovfPipe[PL-2:0], accept && calcOvf(req)};
  end

  assign fifoIn   = '{r: iR, ovf: ovfPipe[PL-1]};
  assign oRES     = fifoOut.r;
  assign oRES_OVF = fifoOut.ovf;
`else
  localparam int FW = RW;
  logic [RW-1:0] fifoIn, fifoOut;

  assign fifoIn = iR;
  assign oRES   = fifoOut;
`endif

  multadd_res_fifo #(
    .W     (FW),
    .DEPTH (FIFO_DEPTH)
  ) uResFifo (
    .iCLK   (iCLK),
    .iRST_N (iRST_N),
    .iPUSH  (busyPipe[PL-1]),
    .iDATA  (fifoIn),
    .iPOP   (pop),
    .oDATA  (fifoOut),
    .oEMPTY (fifoEmpty),
    .oCOUNT (fifoCount)
  );
endmodule

// File: tb/tb_multadd_driver.sv
// tb/tb_multadd_driver.sv - directed bench for multadd_driver with a 2-stage MAC model
module tb_multadd_driver;
  logic        iCLK = 1'b0;
  logic        iRST_N;
  logic        iREQ_VALID;
  logic        oREQ_READY;
  logic [7:0]  iREQ_A0, iREQ_A1, iREQ_B0, iREQ_B1;
  logic        iREQ_SEL;
  logic [7:0]  oA0, oA1, oB0, oB1;
  logic        oSEL;
  logic [16:0] iR;
  logic        oRES_VALID;
  logic        iRES_READY;
  logic [16:0] oRES;
  logic [15:0] oISSUED;
`ifdef MULTADD_DRV_OVF_EN
  logic        oRES_OVF;
  logic        lastOvf;
`endif

  int checks = 0;
  int failures = 0;

  always #5 iCLK = ~iCLK;

  multadd_driver dut (
    .iCLK       (iCLK),
    .iRST_N     (iRST_N),
    .iREQ_VALID (iREQ_VALID),
    .oREQ_READY (oREQ_READY),
    .iREQ_A0    (iREQ_A0),
    .iREQ_A1    (iREQ_A1),
    .iREQ_B0    (iREQ_B0),
    .iREQ_B1    (iREQ_B1),
    .iREQ_SEL   (iREQ_SEL),
    .oA0        (oA0),
    .oA1        (oA1),
    .oB0        (oB0),
    .oB1        (oB1),
    .oSEL       (oSEL),
    .iR         (iR),
    .oRES_VALID (oRES_VALID),
    .iRES_READY (iRES_READY),
    .oRES       (oRES),
    .oISSUED    (oISSUED)
`ifdef MULTADD_DRV_OVF_EN
    ,
    .oRES_OVF   (oRES_OVF)
`endif
  );

  // MAC model: operands registered at E1, result registered at E2.
  logic [7:0] mA0, mA1, mB0, mB1;
  logic       mSel;

  function automatic logic [16:0] macFn(logic [7:0] a0, a1, b0, b1, logic sel);
    logic [33:0] s;
    s = 34'(a0) * 34'(b0) + 34'(a1) * 34'(b1);
    if (!sel) s = s + 34'(a0) * 34'(a1) * 34'(b0) * 34'(b1);
    return s[16:0];
  endfunction

  always_ff @(posedge iCLK) begin
    mA0  <= oA0;
    mA1  <= oA1;
    mB0  <= oB0;
    mB1  <= oB1;
    mSel <= oSEL;
    iR   <= macFn(mA0, mA1, mB0, mB1, mSel);
  end

  task automatic chk(input string tag, input logic [33:0] got, input logic [33:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic setReq(input logic v, input logic [7:0] a0, a1, b0, b1, input logic sel);
    iREQ_VALID = v;
    iREQ_A0 = a0;
    iREQ_A1 = a1;
    iREQ_B0 = b0;
    iREQ_B1 = b1;
    iREQ_SEL = sel;
  endtask

  task automatic runOp(input string tag, input logic [7:0] a0, a1, b0, b1, input logic sel,
                       input logic [16:0] expR, input logic [15:0] expIssued);
    @(negedge iCLK);
    setReq(1'b1, a0, a1, b0, b1, sel);
    chk({tag, "_ready"}, oREQ_READY, 1);
    @(negedge iCLK);
    iREQ_VALID = 1'b0;
    chk({tag, "_issued"}, oISSUED, expIssued);
    chk({tag, "_opA0"}, oA0, a0);
    @(negedge iCLK);
    @(negedge iCLK);
    chk({tag, "_early"}, oRES_VALID, 0);
    @(negedge iCLK);
    chk({tag, "_valid"}, oRES_VALID, 1);
    chk({tag, "_res"}, oRES, expR);
`ifdef MULTADD_DRV_OVF_EN
    lastOvf = oRES_OVF;
`endif
    @(negedge iCLK);
    chk({tag, "_drained"}, oRES_VALID, 0);
  endtask

  logic [7:0]  tA0 [6] = '{8'd1, 8'd10, 8'd2, 8'd100, 8'd7, 8'd255};
  logic [7:0]  tA1 [6] = '{8'd2, 8'd20, 8'd3, 8'd0,   8'd7, 8'd1};
  logic [7:0]  tB0 [6] = '{8'd3, 8'd30, 8'd4, 8'd200, 8'd7, 8'd255};
  logic [7:0]  tB1 [6] = '{8'd4, 8'd40, 8'd5, 8'd7,   8'd7, 8'd1};
  logic        tSel[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [16:0] tExp[6] = '{17'd11, 17'd1100, 17'd143, 17'd20000, 17'd2499, 17'd65026};

  initial begin
    int inIdx, outIdx, seen;
    iRST_N = 1'b0;
    iRES_READY = 1'b1;
    setReq(1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0);
    repeat (3) @(negedge iCLK);
    chk("rst_valid", oRES_VALID, 0);
    chk("rst_issued", oISSUED, 0);
    chk("rst_ops", {oA0, oA1, oB0, oB1, oSEL}, 0);
    chk("rst_res", oRES, 0);
`ifdef MULTADD_DRV_OVF_EN
    chk("rst_ovf", oRES_OVF, 0);
`endif
    iRST_N = 1'b1;
    @(negedge iCLK);
    chk("rst_ready", oREQ_READY, 1);

    runOp("sel1", 8'd3, 8'd5, 8'd4, 8'd6, 1'b1, 17'd42, 16'd1);
`ifdef MULTADD_DRV_OVF_EN
    chk("sel1_ovf", lastOvf, 0);
`endif
    runOp("sel0", 8'd3, 8'd5, 8'd4, 8'd6, 1'b0, 17'd402, 16'd2);
`ifdef MULTADD_DRV_OVF_EN
    chk("sel0_ovf", lastOvf, 0);
`endif
    runOp("max1", 8'd255, 8'd255, 8'd255, 8'd255, 1'b1, 17'd130050, 16'd3);
`ifdef MULTADD_DRV_OVF_EN
    chk("max1_ovf", lastOvf, 0);
`endif
    runOp("max0", 8'd255, 8'd255, 8'd255, 8'd255, 1'b0, 17'd129027, 16'd4);
`ifdef MULTADD_DRV_OVF_EN
    chk("max0_ovf", lastOvf, 1);
`endif

    // Backpressure: consumer stalled, credits must cap accepts at the FIFO depth.
    iRES_READY = 1'b0;
    inIdx = 0;
    outIdx = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge iCLK);
      if (inIdx < 6) setReq(1'b1, tA0[inIdx], tA1[inIdx], tB0[inIdx], tB1[inIdx], tSel[inIdx]);
      else iREQ_VALID = 1'b0;
      if (iREQ_VALID && oREQ_READY) inIdx++;
    end
    @(negedge iCLK);
    chk("bp_accepts", inIdx, 4);
    chk("bp_ready_low", oREQ_READY, 0);
    chk("bp_head_valid", oRES_VALID, 1);
    chk("bp_head", oRES, tExp[0]);

    iRES_READY = 1'b1;
    for (int c = 0; c < 60 && outIdx < 6; c++) begin
      if (inIdx < 6) setReq(1'b1, tA0[inIdx], tA1[inIdx], tB0[inIdx], tB1[inIdx], tSel[inIdx]);
      else iREQ_VALID = 1'b0;
      if (iREQ_VALID && oREQ_READY) inIdx++;
      if (oRES_VALID) begin
        chk($sformatf("bp_res%0d", outIdx), oRES, tExp[outIdx]);
        outIdx++;
      end
      @(negedge iCLK);
    end
    iREQ_VALID = 1'b0;
    chk("bp_all_accepted", inIdx, 6);
    chk("bp_all_returned", outIdx, 6);
    repeat (5) @(negedge iCLK);
    chk("bp_no_dup", oRES_VALID, 0);
    chk("bp_issued", oISSUED, 10);

    // Reset with two ops in flight and one buffered.
    iRES_READY = 1'b0;
    for (int k = 0; k < 3; k++) begin
      setReq(1'b1, tA0[k], tA1[k], tB0[k], tB1[k], tSel[k]);
      chk($sformatf("mid_ready%0d", k), oREQ_READY, 1);
      @(negedge iCLK);
    end
    iREQ_VALID = 1'b0;
    @(negedge iCLK);
    chk("mid_buffered", oRES_VALID, 1);
    iRST_N = 1'b0;
    #1;
    chk("mid_rst_valid", oRES_VALID, 0);
    chk("mid_rst_issued", oISSUED, 0);
    @(negedge iCLK);
    iRST_N = 1'b1;
    iRES_READY = 1'b1;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge iCLK);
      if (oRES_VALID) seen++;
    end
    chk("mid_no_stale", seen, 0);
    chk("mid_issued", oISSUED, 0);
    chk("mid_ready", oREQ_READY, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
